// File: rtl/matmul_sequencer_pkg.sv
// Shared constants for the matrix blocks: sequencer state encoding,
// address/accumulator widths and the row-major address helper.
package matmul_sequencer_pkg;

  localparam int ADDR_W = 32;
  localparam int ACC_W  = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ACC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Linear address of element (row, col) in a row-major matrix of ncols columns.
  function automatic addr_t rm_addr(input addr_t row, input addr_t ncols, input addr_t col);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Memory-side and control handshake bundle between the sequencer and the
// A/B read memories, the C write memory and the controlling host.
interface matmul_sequencer_if
  import matmul_sequencer_pkg::*;
#(
  parameter int DW = 8
);

  logic          start;
  logic          a_ready;
  logic          b_ready;

  logic          rd_a;
  addr_t         rd_a_addr;
  logic [DW-1:0] a_data;

  logic          rd_b;
  addr_t         rd_b_addr;
  logic [DW-1:0] b_data;

  logic          wr_c;
  addr_t         wr_c_addr;
  acc_t          wr_c_data;

  logic          busy;
  logic          done;

  modport master (
    input  start, a_ready, b_ready, a_data, b_data,
    output rd_a, rd_a_addr, rd_b, rd_b_addr,
    output wr_c, wr_c_addr, wr_c_data, busy, done
  );

  modport slave (
    output start, a_ready, b_ready, a_data, b_data,
    input  rd_a, rd_a_addr, rd_b, rd_b_addr,
    input  wr_c, wr_c_addr, wr_c_data, busy, done
  );

endinterface

// File: rtl/matmul_sequencer_mac.sv
// Multiply-accumulate: unsigned DW x DW product zero-extended into a
// wrapping accumulator; clear has priority over enable.
module mac_unit
  import matmul_sequencer_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output acc_t          acc_o
);

  logic [2*DW-1:0] prod;
  acc_t            acc_q;
  acc_t            acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (enable_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences C = A x B one element at a time: K read/accumulate pairs per
// element, then a single write of the finished dot product.
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int M  = 2,
  parameter int K  = 2,
  parameter int P  = 2,
  parameter int DW = 8
) (
  input logic                clk,
  input logic                rst,
  matmul_sequencer_if.master bus
);

  localparam addr_t M_LAST = addr_t'(M - 1);
  localparam addr_t K_LAST = addr_t'(K - 1);
  localparam addr_t P_LAST = addr_t'(P - 1);
  localparam addr_t K_COLS = addr_t'(K);
  localparam addr_t P_COLS = addr_t'(P);

  state_e state_q, state_d;
  addr_t  i_q, i_d;
  addr_t  j_q, j_d;
  addr_t  k_q, k_d;

  logic   rd_en;
  logic   wr_en;
  logic   mac_clr;
  logic   mac_en;
  acc_t   acc;

  addr_t  a_addr_live, b_addr_live, c_addr_live;
  addr_t  a_addr_q, b_addr_q, c_addr_q;
  acc_t   c_data_q;

  mac_unit #(.DW(DW)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (mac_clr),
    .enable_i (mac_en),
    .a_i      (bus.a_data),
    .b_i      (bus.b_data),
    .acc_o    (acc)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mac_clr = 1'b1;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        if (bus.start && bus.a_ready && bus.b_ready) begin
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        rd_en   = 1'b1;
        state_d = ST_ACC;
      end

      ST_ACC: begin
        mac_en = 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_WRITE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_READ;
        end
      end

      ST_WRITE: begin
        wr_en   = 1'b1;
        mac_clr = 1'b1;
        if (j_q == P_LAST) begin
          j_d = '0;
          if (i_q == M_LAST) begin
            i_d     = '0;
            state_d = ST_DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = ST_READ;
          end
        end else begin
          j_d     = j_q + 1'b1;
          state_d = ST_READ;
        end
      end

      // Hold done until the host drops start, so a level start cannot retrigger.
      ST_DONE: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every one updates from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign a_addr_live = rm_addr(i_q, K_COLS, k_q);
  assign b_addr_live = rm_addr(k_q, P_COLS, j_q);
  assign c_addr_live = rm_addr(i_q, P_COLS, j_q);

  // Last-issued address/data, so the bus holds steady while strobes are low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else begin
      if (rd_en) begin
        a_addr_q <= a_addr_live;
        b_addr_q <= b_addr_live;
      end
      if (wr_en) begin
        c_addr_q <= c_addr_live;
        c_data_q <= acc;
      end
    end
  end

  assign bus.rd_a      = rd_en;
  assign bus.rd_b      = rd_en;
  assign bus.rd_a_addr = rd_en ? a_addr_live : a_addr_q;
  assign bus.rd_b_addr = rd_en ? b_addr_live : b_addr_q;
  assign bus.wr_c      = wr_en;
  assign bus.wr_c_addr = wr_en ? c_addr_live : c_addr_q;
  assign bus.wr_c_data = wr_en ? acc : c_data_q;
  assign bus.busy      = (state_q == ST_READ) || (state_q == ST_ACC) || (state_q == ST_WRITE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter M, default 2, rows of A and C.
REQ-002 SHALL have parameter K, default 2, columns of A and rows of B.
REQ-003 SHALL have parameter P, default 2, columns of B and C.
REQ-004 SHALL have parameter DW, default 8, element width (unsigned).
REQ-005 SHALL have port clk, input, 1: system clock, all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1: level request to compute C = A x B.
REQ-008 SHALL have port a_ready, input, 1: matrix A memory fully loaded (UART loader complete flag).
REQ-009 SHALL have port b_ready, input, 1: matrix B memory fully loaded.
REQ-010 SHALL have port rd_a, input/output: output, 1: read enable to A memory.
REQ-011 SHALL have port rd_a_addr, output, 32: A read address, row-major, i*K+k.
REQ-012 SHALL have port a_data, input, DW: A read data, valid one cycle after rd_a.
REQ-013 SHALL have port rd_b, output, 1: read enable to B memory.
REQ-014 SHALL have port rd_b_addr, output, 32: B read address, row-major, k*P+j.
REQ-015 SHALL have port b_data, input, DW: B read data, valid one cycle after rd_b.
REQ-016 SHALL have port wr_c, output, 1: one-cycle write strobe to C memory.
REQ-017 SHALL have port wr_c_addr, output, 32: C write address, i*P+j.
REQ-018 SHALL have port wr_c_data, output, 32: accumulated element C[i][j].
REQ-019 SHALL have port busy, output, 1: high in every state except IDLE and DONE.
REQ-020 SHALL have port done, output, 1: high in DONE only.

Function
REQ-021 SHALL implement FSM states IDLE, READ, ACC, WRITE, DONE; unlisted encodings return to IDLE.
REQ-022 IDLE -> READ when start && a_ready && b_ready; otherwise remain IDLE, indices and accumulator zero.
REQ-023 READ SHALL assert rd_a and rd_b together for exactly one cycle with addresses from current i, j, k; next state ACC.
REQ-024 ACC SHALL add a_data*b_data (2*DW product, zero-extended) to a 32-bit accumulator; k<K-1: k+1, -> READ; k=K-1: k=0, -> WRITE.
REQ-025 WRITE SHALL assert wr_c for one cycle with wr_c_data = accumulator (including the final ACC term), then clear accumulator.
REQ-026 Index advance after WRITE: j+1; on j=P-1, j=0 and i+1; on i=M-1 and j=P-1 -> DONE, else -> READ.
REQ-027 Result order SHALL be row-major, addresses 0..M*P-1 each written exactly once.
REQ-028 Latency: first rd_a one cycle after start accepted; per element 2K+1 cycles; total M*P*(2K+1) cycles from READ entry to DONE entry (20 for defaults).
REQ-029 DONE SHALL hold done=1 until start is low, then -> IDLE next cycle; start held high in DONE does not restart.
REQ-030 start changes, a_ready or b_ready deassertion while busy SHALL be ignored; sequence completes.
REQ-031 rd_a, rd_b, wr_c SHALL be low in IDLE, ACC, DONE; addresses hold last value when strobes low.
REQ-032 Accumulator SHALL wrap modulo 2^32; no saturation (no overflow for DW=8, K<=66000).

Reset
REQ-033 rst SHALL immediately force IDLE, i=j=k=0, accumulator 0, all outputs 0, regardless of state.
REQ-034 Reset mid-sequence SHALL abort without further C writes; new start after release restarts from element 0.

Structure
REQ-035 State encodings and address/accumulator widths SHALL live in a shared `include constants file used by all matrix blocks.
REQ-036 Multiply-accumulate SHALL be a sub-module mac_unit (clear, enable, a, b, acc out); FSM and index counters stay in matmul_sequencer.

Verification
REQ-037 A=[1,2;3,4], B=[5,6;7,8], start=1 -> writes (0,19),(1,22),(2,43),(3,50); done after 20 cycles.
REQ-038 All elements 255, defaults -> all four writes carry 130050.
REQ-039 start=1, a_ready=1, b_ready=0 for 10 cycles -> no rd_a/rd_b, busy=0; raising b_ready -> sequence starts next cycle.
REQ-040 rst asserted during second element's ACC -> outputs zero same cycle, no further wr_c; restart yields REQ-037 results.
REQ-041 start toggled mid-run and held high in DONE -> exactly 4 writes, no restart until start goes low then high.
REQ-042 M=2, K=3, P=1 with A=[1,2,3;4,5,6], B=[1;1;1] -> writes (0,6),(1,15), 14 cycles.
